// File: rtl/div_iter_pkg.sv
// Shared types for the iterative divider: FSM state encoding and common word aliases.
package div_iter_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [2*XLEN-1:0] u64;
  typedef logic              u1;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] t;

  always_comb begin
    t        = {rem, dvd_msb};
    q_bit    = (t >= {1'b0, dvs});
    // The true difference always fits in WIDTH bits, so the low-order subtract is exact.
    rem_next = t[WIDTH-1:0] - (q_bit ? dvs : '0);
  end

endmodule

// File: rtl/div_iter.sv
// Multicycle radix-2 restoring unsigned divider; c = {remainder, quotient}.
// Handshake: requester holds valid and a/b steady until done; done is a one-cycle
// pulse, and dropping valid before done aborts the divide without touching c.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] c,
  output div_state_t         dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  div_state_t       state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  u1                q_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[WIDTH-1]),
    .dvs      (dvs),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Quotient bits fill the dividend register from the bottom as its top bits are consumed.
  assign quo_next  = {dvd[WIDTH-2:0], q_bit};
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      DIV_IDLE: if (valid) state_next = DIV_BUSY;
      DIV_BUSY: begin
        if (!valid)               state_next = DIV_IDLE;
        else if (cnt == CNT_LAST) state_next = DIV_DONE;
      end
      DIV_DONE: begin
        done       = 1'b1;
        state_next = DIV_IDLE;
      end
      default:  state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      c     <= '0;
    end else begin
      state <= state_next;
      case (state)
        DIV_IDLE: begin
          if (valid) begin
            dvd <= a;
            dvs <= b;
            rem <= '0;
            cnt <= '0;
          end
        end
        DIV_BUSY: begin
          if (valid) begin
            dvd <= quo_next;
            rem <= rem_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) c <= {rem_next, quo_next};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed and randomised bench for div_iter: latency, results, abort, back-to-back, reset.
module tb_div_iter;
  import div_iter_pkg::*;

  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic        valid  = 1'b0;
  logic [31:0] a      = '0;
  logic [31:0] b      = '0;
  logic        done;
  logic [63:0] c;
  div_state_t  dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] last_c   = '0;
  int          lat;

  // clock / reset
  always #5 clk = ~clk;

  div_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .valid     (valid),
    .a         (a),
    .b         (b),
    .done      (done),
    .c         (c),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    return {x % y, x / y};
  endfunction

  // Steps until done rises (bounded); lat is the cycle count from the current cycle.
  task automatic wait_done(input string tag, input int exp_lat, output int got_lat);
    got_lat = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (done) begin
        got_lat = k;
        break;
      end
    end
    check({tag, "_lat"}, 64'(got_lat), 64'(exp_lat));
  endtask

  // Full handshake: request this cycle, expect done at +33, then release valid.
  task automatic do_div(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp_c);
    int l;
    valid = 1'b1;
    a     = x;
    b     = y;
    wait_done(tag, 33, l);
    check({tag, "_c"}, c, exp_c);
    valid = 1'b0;
    step();
    check({tag, "_done_after"}, 64'(done), 64'd0);
    last_c = exp_c;
  endtask

  initial begin
    logic [31:0] ra, rb;

    // reset state
    resetn = 1'b0;
    valid  = 1'b1;
    a      = 32'd55;
    b      = 32'd3;
    repeat (3) step();
    check("rst_done", 64'(done), 64'd0);
    check("rst_c", c, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(DIV_IDLE));
    valid  = 1'b0;
    resetn = 1'b1;
    step();

    // 1: 100/7, done exactly at cycle 33 and not before
    valid = 1'b1;
    a     = 32'd100;
    b     = 32'd7;
    check("t1_done_c0", 64'(done), 64'd0);
    do_div("t1", 32'd100, 32'd7, {32'd2, 32'd14});

    // 2: extremes
    do_div("t2a", 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF});
    do_div("t2b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'd0, 32'd1});
    do_div("t2c", 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0});
    do_div("t2d", 32'd3, 32'd10, {32'd3, 32'd0});
    do_div("t2e", 32'd0, 32'd9, 64'd0);

    // 3: divide by zero
    do_div("t3", 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});

    // 4: abort at cycle 10, new request at cycle 12
    valid = 1'b1;
    a     = 32'd100;
    b     = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("t4_no_done", 64'(done), 64'd0);
    end
    valid = 1'b0;
    step();
    check("t4_state_abort", 64'(dbg_state), 64'(DIV_IDLE));
    check("t4_c_kept", c, last_c);
    step();
    check("t4_no_done12", 64'(done), 64'd0);
    valid = 1'b1;
    a     = 32'd9;
    b     = 32'd4;
    wait_done("t4", 33, lat);
    check("t4_c", c, {32'd1, 32'd2});
    valid = 1'b0;
    step();

    // 5: back-to-back with operands switched on the DONE cycle
    valid = 1'b1;
    a     = 32'd100;
    b     = 32'd7;
    wait_done("t5a", 33, lat);
    check("t5a_c", c, {32'd2, 32'd14});
    a = 32'd9;
    b = 32'd4;
    wait_done("t5b", 34, lat);
    check("t5b_c", c, {32'd1, 32'd2});
    valid = 1'b0;
    step();

    // 6: reset at cycle 15, restart right after
    valid = 1'b1;
    a     = 32'd100;
    b     = 32'd7;
    repeat (15) step();
    resetn = 1'b0;
    step();
    check("t6_done", 64'(done), 64'd0);
    check("t6_c", c, 64'd0);
    check("t6_state", 64'(dbg_state), 64'(DIV_IDLE));
    resetn = 1'b1;
    wait_done("t6", 33, lat);
    check("t6_c_restart", c, {32'd2, 32'd14});
    valid = 1'b0;
    step();

    // random pairs against a reference, biased towards b=0, b=1 and b near a
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'($urandom_range(2, 255));
        3:       rb = ra + 32'($urandom_range(0, 3));
        4:       begin ra = 32'($urandom_range(0, 1000)); rb = $urandom; end
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      do_div("rnd", ra, rb, ref_div(ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
